timer_scheduler: RTL and testbench

TIMER_SCHEDULER -- requirements
Module: timer_scheduler

---
 rtl/timer_pkg.sv | 21 ++
 rtl/down_counter.sv | 31 +++
 rtl/timer_scheduler.sv | 116 +++++++++++
 tb/tb_timer_scheduler.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the timer scheduler: FSM state encoding, default
// counter width and the two-requester round-robin winner selection.
package timer_pkg;

  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // With both requesting, the one not granted last wins; otherwise the lone requester wins.
  function automatic logic pickWinner(input logic [1:0] reqVec, input logic lastOwner);
    if (reqVec == 2'b11) begin
      return ~lastOwner;
    end
    return reqVec[1];
  endfunction

endpackage

// File: rtl/down_counter.sv
// Loadable down counter that saturates at zero; shared interval counter of
// the timer scheduler.
module down_counter
  import timer_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  // A load always wins over a decrement; decrementing stops at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= din;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/timer_scheduler.sv
// Two-requester interval timer: round-robin grant of one shared down
// counter, one-cycle done pulse on completion, abort when the owner lets go.
module timer_scheduler
  import timer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [CNT_W-1:0] len0,
  input  logic [CNT_W-1:0] len1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic [1:0]       done,
  output logic [CNT_W-1:0] count
);

  state_e     state_q;
  logic [1:0] gnt_q;
  logic [1:0] done_q;
  logic       owner_q;
  logic       last_q;

  logic             winner;
  logic             ownerReq;
  logic             cntLoad;
  logic             cntEn;
  logic [CNT_W-1:0] cntDin;

  assign winner   = pickWinner(req, last_q);
  assign ownerReq = req[owner_q];

  // Counter control: load the winner's length at grant, load zero on abort,
  // otherwise count down while the owner keeps its request up.
  always_comb begin
    cntLoad = 1'b0;
    cntEn   = 1'b0;
    cntDin  = '0;
    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          cntLoad = 1'b1;
          cntDin  = winner ? len1 : len0;
        end
      end
      RUN: begin
        if (!ownerReq) begin
          cntLoad = 1'b1;
        end else begin
          cntEn = 1'b1;
        end
      end
      default: ;
    endcase
  end

  down_counter #(
    .W(CNT_W)
  ) u_counter (
    .clk  (clk),
    .reset(reset),
    .load (cntLoad),
    .en   (cntEn),
    .din  (cntDin),
    .count(count)
  );

  // Grant FSM with registered grant and done outputs. The last-granted
  // pointer moves at every grant, so an aborted interval still counts as a turn.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 2'b00;
          if (req != 2'b00) begin
            state_q <= RUN;
            gnt_q   <= winner ? 2'b10 : 2'b01;
            owner_q <= winner;
            last_q  <= winner;
          end
        end
        RUN: begin
          if (!ownerReq) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
          end else if (count == '0) begin
            state_q <= DONE;
            done_q  <= gnt_q;
          end
        end
        DONE: begin
          state_q <= IDLE;
          gnt_q   <= 2'b00;
          done_q  <= 2'b00;
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= 2'b00;
          done_q  <= 2'b00;
        end
      endcase
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = |gnt_q;

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed testbench for timer_scheduler: single interval, contention and
// fairness, zero length, abort, and asynchronous reset during an interval.
module tb_timer_scheduler;

  logic       clk;
  logic       reset;
  logic [1:0] req;
  logic [3:0] len0;
  logic [3:0] len1;
  logic [1:0] gnt;
  logic       busy;
  logic [1:0] done;
  logic [3:0] count;

  int         assertCount;
  int         failCount;
  logic [1:0] prevDone;

  timer_scheduler #(
    .CNT_W(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .req  (req),
    .len0 (len0),
    .len1 (len1),
    .gnt  (gnt),
    .busy (busy),
    .done (done),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] expGnt, input logic expBusy,
                             input logic [1:0] expDone, input logic [3:0] expCount);
    checkEq({tag, ".gnt"},   32'(gnt),   32'(expGnt));
    checkEq({tag, ".busy"},  32'(busy),  32'(expBusy));
    checkEq({tag, ".done"},  32'(done),  32'(expDone));
    checkEq({tag, ".count"}, 32'(count), 32'(expCount));
  endtask

  // No directed interval is longer than 9, so a larger count means a wrap.
  task automatic checkInvariants();
    checkEq("onehot",     32'($countones(gnt) <= 1), 32'd1);
    checkEq("busy_or",    32'(busy), 32'(|gnt));
    checkEq("done_width", 32'((done != 2'b00) && (prevDone != 2'b00)), 32'd0);
    checkEq("no_wrap",    32'(count <= 4'd9), 32'd1);
    prevDone = done;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    checkInvariants();
  endtask

  task automatic applyStimulus(input logic [1:0] reqV, input logic [3:0] l0, input logic [3:0] l1);
    req  = reqV;
    len0 = l0;
    len1 = l1;
  endtask

  task automatic doReset();
    reset = 1'b0;
    #1;
    checkOutput("reset_async", 2'b00, 1'b0, 2'b00, 4'd0);
    step();
    reset = 1'b1;
  endtask

  initial begin
    clk         = 1'b0;
    reset       = 1'b0;
    req         = 2'b00;
    len0        = 4'd0;
    len1        = 4'd0;
    prevDone    = 2'b00;
    assertCount = 0;
    failCount   = 0;

    #1;
    checkOutput("reset", 2'b00, 1'b0, 2'b00, 4'd0);
    step();
    step();
    reset = 1'b1;

    $display("[TB] single interval");
    applyStimulus(2'b01, 4'd3, 4'd0);
    step(); checkOutput("single_grant", 2'b01, 1'b1, 2'b00, 4'd3);
    applyStimulus(2'b11, 4'd3, 4'd5);
    step(); checkOutput("single_c2",    2'b01, 1'b1, 2'b00, 4'd2);
    step(); checkOutput("single_c1",    2'b01, 1'b1, 2'b00, 4'd1);
    step(); checkOutput("single_c0",    2'b01, 1'b1, 2'b00, 4'd0);
    applyStimulus(2'b01, 4'd3, 4'd0);
    step(); checkOutput("single_done",  2'b01, 1'b1, 2'b01, 4'd0);
    applyStimulus(2'b00, 4'd3, 4'd0);
    step(); checkOutput("single_idle",  2'b00, 1'b0, 2'b00, 4'd0);

    $display("[TB] contention and fairness");
    doReset();
    applyStimulus(2'b11, 4'd2, 4'd1);
    step(); checkOutput("rr_g0",      2'b01, 1'b1, 2'b00, 4'd2);
    step(); checkOutput("rr_g0_c1",   2'b01, 1'b1, 2'b00, 4'd1);
    step(); checkOutput("rr_g0_c0",   2'b01, 1'b1, 2'b00, 4'd0);
    step(); checkOutput("rr_g0_done", 2'b01, 1'b1, 2'b01, 4'd0);
    step(); checkOutput("rr_idle1",   2'b00, 1'b0, 2'b00, 4'd0);
    step(); checkOutput("rr_g1",      2'b10, 1'b1, 2'b00, 4'd1);
    step(); checkOutput("rr_g1_c0",   2'b10, 1'b1, 2'b00, 4'd0);
    step(); checkOutput("rr_g1_done", 2'b10, 1'b1, 2'b10, 4'd0);
    step(); checkOutput("rr_idle2",   2'b00, 1'b0, 2'b00, 4'd0);
    step(); checkOutput("rr_g0_again", 2'b01, 1'b1, 2'b00, 4'd2);
    applyStimulus(2'b00, 4'd2, 4'd1);
    step(); checkOutput("rr_abort",   2'b00, 1'b0, 2'b00, 4'd0);

    $display("[TB] zero length");
    applyStimulus(2'b10, 4'd7, 4'd0);
    step(); checkOutput("zero_grant", 2'b10, 1'b1, 2'b00, 4'd0);
    step(); checkOutput("zero_done",  2'b10, 1'b1, 2'b10, 4'd0);
    applyStimulus(2'b00, 4'd0, 4'd0);
    step(); checkOutput("zero_idle",  2'b00, 1'b0, 2'b00, 4'd0);

    $display("[TB] abort");
    applyStimulus(2'b01, 4'd9, 4'd0);
    step(); checkOutput("abort_grant", 2'b01, 1'b1, 2'b00, 4'd9);
    for (int i = 8; i >= 5; i--) begin
      step(); checkOutput("abort_cnt", 2'b01, 1'b1, 2'b00, 4'(i));
    end
    applyStimulus(2'b00, 4'd9, 4'd0);
    step(); checkOutput("abort_idle",  2'b00, 1'b0, 2'b00, 4'd0);
    step(); checkOutput("abort_quiet", 2'b00, 1'b0, 2'b00, 4'd0);

    $display("[TB] async reset mid-run");
    applyStimulus(2'b01, 4'd6, 4'd0);
    step(); checkOutput("ar_grant", 2'b01, 1'b1, 2'b00, 4'd6);
    step(); checkOutput("ar_c5",    2'b01, 1'b1, 2'b00, 4'd5);
    step(); checkOutput("ar_c4",    2'b01, 1'b1, 2'b00, 4'd4);
    #3;
    reset = 1'b0;
    #1;
    checkOutput("ar_immediate", 2'b00, 1'b0, 2'b00, 4'd0);
    applyStimulus(2'b11, 4'd6, 4'd2);
    step(); checkOutput("ar_held",  2'b00, 1'b0, 2'b00, 4'd0);
    reset = 1'b1;
    step(); checkOutput("ar_regrant", 2'b01, 1'b1, 2'b00, 4'd6);
    applyStimulus(2'b00, 4'd6, 4'd2);
    step(); checkOutput("ar_final", 2'b00, 1'b0, 2'b00, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
